// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core and its program loader.
// Holds the instruction-memory geometry, opcode encodings, the loader
// frame header byte and the loader FSM state type.
package cpu_pkg;

  localparam int unsigned CMD_SIZE      = 19;
  localparam int unsigned CMD_MEM_SIZE  = 32;
  localparam int unsigned CMD_ADDR_SIZE = $clog2(CMD_MEM_SIZE);

  // 4-bit opcode in cmd[18:15]
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LTM = 4'd1,
    OP_MTR = 4'd2,
    OP_RTM = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_MUL = 4'd6,
    OP_DIV = 4'd7
  } opcode_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_LEN,
    LD_B0,
    LD_B1,
    LD_B2,
    LD_WRITE,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader for the CPU instruction memory.
// Frame: 0xA5, N (1..CMD_MEM_SIZE), N big-endian 3-byte words, XOR checksum
// of the word bytes. Each word is written through a single write port at
// consecutive addresses while the CPU is held in reset.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream (transfer on valid && ready)
//   wr_en/wr_addr/wr_data      instruction-memory write port
//   cpu_hold        OR'd into CPU reset while loading or after an error
//   done, error     result of the last frame (levels)
//   word_count      words written in the current/last frame
module prog_loader #(
  parameter int unsigned CMD_SIZE      = cpu_pkg::CMD_SIZE,
  parameter int unsigned CMD_MEM_SIZE  = cpu_pkg::CMD_MEM_SIZE,
  parameter int unsigned CMD_ADDR_SIZE = $clog2(CMD_MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [CMD_ADDR_SIZE-1:0] wr_addr,
  output logic [CMD_SIZE-1:0]      wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [CMD_ADDR_SIZE:0]   word_count
);
  import cpu_pkg::*;

  // Bits of byte0 that carry word data; the rest must be zero.
  localparam int unsigned B0_BITS = CMD_SIZE - 16;
  localparam logic [7:0] MAX_LEN = 8'(CMD_MEM_SIZE);
  localparam logic [CMD_ADDR_SIZE-1:0] LAST_ADDR = CMD_ADDR_SIZE'(CMD_MEM_SIZE - 1);

  ld_state_e                state_q, state_d;
  logic [CMD_ADDR_SIZE:0]   len_q, len_d;
  logic [CMD_SIZE-1:0]      data_q, data_d;
  logic [7:0]               csum_q, csum_d;
  logic [CMD_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [CMD_ADDR_SIZE:0]   wc_q, wc_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     hold_q, hold_d;
  logic                     accept;

  assign in_ready   = !reset && (state_q != LD_WRITE);
  assign accept     = in_valid && in_ready;
  assign wr_en      = (state_q == LD_WRITE);
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    data_d  = data_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;
    case (state_q)
      // IDLE, DONE and ERR all hunt for a header and discard anything else.
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (accept && in_data == FRAME_HDR) begin
          state_d = LD_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          wc_d    = '0;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      LD_LEN: begin
        if (accept) begin
          if (in_data == 8'd0 || in_data > MAX_LEN) begin
            state_d = LD_ERR;
            error_d = 1'b1;
          end else begin
            len_d   = in_data[CMD_ADDR_SIZE:0];
            state_d = LD_B0;
          end
        end
      end
      LD_B0: begin
        if (accept) begin
          if (in_data[7:B0_BITS] != '0) begin
            state_d = LD_ERR;
            error_d = 1'b1;
          end else begin
            data_d[CMD_SIZE-1:16] = in_data[B0_BITS-1:0];
            csum_d  = csum_q ^ in_data;
            state_d = LD_B1;
          end
        end
      end
      LD_B1: begin
        if (accept) begin
          data_d[15:8] = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = LD_B2;
        end
      end
      LD_B2: begin
        if (accept) begin
          data_d[7:0] = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        wc_d = wc_q + (CMD_ADDR_SIZE+1)'(1);
        // Hold at the top address rather than wrapping after a full-memory frame.
        if (addr_q != LAST_ADDR) addr_d = addr_q + CMD_ADDR_SIZE'(1);
        state_d = (wc_d == len_q) ? LD_CSUM : LD_B0;
      end
      LD_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = LD_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      len_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [18:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [5:0]  word_count;

  int vecs = 0;
  int errs = 0;
  int ready_in_write = 0;
  logic [4:0]  wq_addr[$];
  logic [18:0] wq_data[$];

  prog_loader #(.CMD_SIZE(19), .CMD_MEM_SIZE(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write-port monitor: log every strobe cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      if (in_ready !== 1'b0) ready_in_write++;
    end
  end

  task automatic send(input logic [7:0] b, input int unsigned gap);
    logic rdy;
    int unsigned tries;
    for (int unsigned g = 0; g < gap; g++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    rdy = 1'b0;
    tries = 0;
    while (!rdy && tries < 50) begin
      rdy = in_ready;
      @(posedge clk);
      tries++;
      if (!rdy) @(negedge clk);
    end
    if (!rdy) begin
      $display("FAIL send_timeout byte=%h in_ready stuck at %b, required 1", b, in_ready);
      errs++;
    end
    vecs++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk); in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int unsigned gapmod);
    for (int unsigned i = 0; i < f.size(); i++)
      send(f[i], (gapmod == 0) ? 0 : (i % gapmod));
    idle(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    vecs++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got=%b exp=0", in_ready); errs++; end
    vecs++; if ({wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count} !== '0) begin
      $display("FAIL rst_outputs got wr_en=%b addr=%h data=%h hold=%b done=%b err=%b wc=%0d exp all 0",
               wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count); errs++; end
    reset = 1'b0;
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1) begin $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); errs++; end
  endtask

  task automatic test_idle_garbage();
    wq_addr.delete(); wq_data.delete();
    send(8'h00, 0); send(8'hFF, 0); idle(1);
    vecs++; if ({cpu_hold, done, error} !== 3'b000 || wq_addr.size() != 0) begin
      $display("FAIL idle_garbage got hold=%b done=%b err=%b writes=%0d exp 0/0/0/0",
               cpu_hold, done, error, wq_addr.size()); errs++; end
  endtask

  task automatic test_single_word();
    wq_addr.delete(); wq_data.delete();
    send(8'hA5, 0); idle(1);
    vecs++; if (cpu_hold !== 1'b1) begin $display("FAIL hdr_hold got=%b exp=1", cpu_hold); errs++; end
    send_frame('{8'h01, 8'h00, 8'h8C, 8'h05, 8'h89}, 0);
    vecs++; if (wq_addr.size() != 1) begin $display("FAIL single_nwrites got=%0d exp=1", wq_addr.size()); errs++; end
    else begin
      vecs++; if (wq_addr[0] !== 5'd0 || wq_data[0] !== 19'h08C05) begin
        $display("FAIL single_write got addr=%h data=%h exp addr=00 data=08c05", wq_addr[0], wq_data[0]); errs++; end
    end
    vecs++; if ({done, cpu_hold, error} !== 3'b100 || word_count !== 6'd1) begin
      $display("FAIL single_status got done=%b hold=%b err=%b wc=%0d exp 1/0/0/1", done, cpu_hold, error, word_count); errs++; end
  endtask

  task automatic test_full_memory();
    logic [7:0] f[$];
    wq_addr.delete(); wq_data.delete();
    f = '{8'hA5, 8'h20};
    for (int unsigned i = 0; i < 32; i++) begin
      f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'(i));
    end
    f.push_back(8'h00); // XOR of 0..31 is 0
    send_frame(f, 0);
    vecs++; if (wq_addr.size() != 32) begin $display("FAIL full_nwrites got=%0d exp=32", wq_addr.size()); errs++; end
    else for (int unsigned i = 0; i < 32; i++) begin
      vecs++; if (wq_addr[i] !== 5'(i) || wq_data[i] !== 19'(i)) begin
        $display("FAIL full_word%0d got addr=%h data=%h exp addr=%h data=%h", i, wq_addr[i], wq_data[i], 5'(i), 19'(i)); errs++; end
    end
    vecs++; if ({done, cpu_hold, error} !== 3'b100 || word_count !== 6'd32 || wr_addr !== 5'd31) begin
      $display("FAIL full_status got done=%b hold=%b err=%b wc=%0d addr=%0d exp 1/0/0/32/31",
               done, cpu_hold, error, word_count, wr_addr); errs++; end
  endtask

  task automatic test_bad_checksum();
    wq_addr.delete(); wq_data.delete();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h8C, 8'h05, 8'h88}, 0);
    vecs++; if (wq_addr.size() != 1) begin $display("FAIL badck_nwrites got=%0d exp=1", wq_addr.size()); errs++; end
    vecs++; if ({done, cpu_hold, error} !== 3'b011) begin
      $display("FAIL badck_status got done=%b hold=%b err=%b exp 0/1/1", done, cpu_hold, error); errs++; end
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h8C, 8'h05, 8'h89}, 0);
    vecs++; if ({done, cpu_hold, error} !== 3'b100) begin
      $display("FAIL badck_recover got done=%b hold=%b err=%b exp 1/0/0", done, cpu_hold, error); errs++; end
  endtask

  task automatic test_framing();
    logic [7:0] frames[3][$];
    frames[0] = '{8'hA5, 8'h00};
    frames[1] = '{8'hA5, 8'h21};
    frames[2] = '{8'hA5, 8'h01, 8'h08};
    for (int unsigned k = 0; k < 3; k++) begin
      wq_addr.delete(); wq_data.delete();
      send_frame(frames[k], 0);
      // Garbage while in ERR, including bytes that would form a word.
      send_frame('{8'h00, 8'hFF, 8'h00, 8'h8C, 8'h05}, 0);
      vecs++; if ({done, cpu_hold, error} !== 3'b011 || wq_addr.size() != 0 || in_ready !== 1'b1) begin
        $display("FAIL framing%0d got done=%b hold=%b err=%b writes=%0d rdy=%b exp 0/1/1/0/1",
                 k, done, cpu_hold, error, wq_addr.size(), in_ready); errs++; end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  f[$];
    logic [18:0] exp_d[3];
    f = '{8'hA5, 8'h03, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'h60};
    exp_d = '{19'h12345, 19'h7FF00, 19'h05AA5};
    for (int unsigned pass = 0; pass < 2; pass++) begin
      wq_addr.delete(); wq_data.delete();
      ready_in_write = 0;
      send_frame(f, pass * 3);
      vecs++; if (wq_addr.size() != 3) begin $display("FAIL bp%0d_nwrites got=%0d exp=3", pass, wq_addr.size()); errs++; end
      else for (int unsigned i = 0; i < 3; i++) begin
        vecs++; if (wq_addr[i] !== 5'(i) || wq_data[i] !== exp_d[i]) begin
          $display("FAIL bp%0d_word%0d got addr=%h data=%h exp addr=%h data=%h", pass, i, wq_addr[i], wq_data[i], 5'(i), exp_d[i]); errs++; end
      end
      vecs++; if (ready_in_write != 0) begin $display("FAIL bp%0d_ready_in_write got=%0d exp=0", pass, ready_in_write); errs++; end
      vecs++; if ({done, error} !== 2'b10 || word_count !== 6'd3) begin
        $display("FAIL bp%0d_status got done=%b err=%b wc=%0d exp 1/0/3", pass, done, error, word_count); errs++; end
    end
  endtask

  task automatic test_reset_mid();
    wq_addr.delete(); wq_data.delete();
    send_frame('{8'hA5, 8'h04, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h22}, 0);
    idle(2);
    vecs++; if (cpu_hold !== 1'b1 || word_count !== 6'd2 || wq_addr.size() != 2) begin
      $display("FAIL mid_pre got hold=%b wc=%0d writes=%0d exp 1/2/2", cpu_hold, word_count, wq_addr.size()); errs++; end
    reset = 1'b1;
    @(negedge clk);
    vecs++; if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count} !== '0) begin
      $display("FAIL mid_reset got rdy=%b wr_en=%b addr=%h data=%h hold=%b done=%b err=%b wc=%0d exp all 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count); errs++; end
    reset = 1'b0;
    wq_addr.delete(); wq_data.delete();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h33, 8'h33}, 0);
    vecs++; if (wq_addr.size() != 1 || wq_addr[0] !== 5'd0 || wq_data[0] !== 19'h00033 || done !== 1'b1) begin
      $display("FAIL mid_reload got writes=%0d addr=%h data=%h done=%b exp 1/00/00033/1",
               wq_addr.size(), (wq_addr.size() > 0) ? wq_addr[0] : 5'h1F,
               (wq_data.size() > 0) ? wq_data[0] : 19'h7FFFF, done); errs++; end
  endtask

  initial begin
    test_reset();
    test_idle_garbage();
    test_single_word();
    test_full_memory();
    test_bad_checksum();
    test_framing();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the CPU's 32×19-bit instruction memory before execution. It accepts a framed byte stream on a valid/ready input, packs every three bytes into one 19-bit command word, and writes it through a single write port at consecutive addresses. It holds the CPU in reset while loading and signals completion or a framing/checksum error. It is the writer side of the instruction memory the CPU fetches from.

## Interface
- CMD_SIZE, 19, command word width (4-bit opcode + operand fields).
- CMD_MEM_SIZE, 32, instruction memory depth in words.
- CMD_ADDR_SIZE, $clog2(CMD_MEM_SIZE), write address width.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at posedge clk.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  CMD_ADDR_SIZE  write address.
- wr_data  out  CMD_SIZE  write data.
- cpu_hold  out  1  held high while a load is in progress or after an error; OR'd into the CPU reset.
- done  out  1  last frame loaded and checksum correct; level.
- error  out  1  last frame aborted; level.
- word_count  out  CMD_ADDR_SIZE+1  words written in the current/last frame.

## Operation
- Frame: header 0xA5, length N (1..CMD_MEM_SIZE), N words of 3 bytes big-endian, checksum = XOR of all 3N word bytes. Header and length are not included in the checksum.
- Word packing: byte0[2:0] becomes wr_data[18:16], byte1 becomes [15:8], byte2 becomes [7:0]. byte0[7:3] must be 0.
- FSM states: IDLE, LEN, B0, B1, B2, WRITE, CSUM, DONE, ERR.
  - IDLE: non-0xA5 bytes are discarded. 0xA5 goes to LEN and sets cpu_hold=1, done=0, error=0, word_count=0, wr_addr=0.
  - LEN: N=0 or N>CMD_MEM_SIZE goes to ERR; otherwise latch N and go to B0.
  - B0: byte0[7:3]≠0 goes to ERR; otherwise go to B1. B1 goes to B2.
  - B2 goes to WRITE.
  - WRITE: in_ready=0 and wr_en=1 for exactly one cycle. Then wr_addr increments and word_count increments. If word_count reaches N, go to CSUM; otherwise go to B0.
  - CSUM: a match goes to DONE (done=1, cpu_hold=0). A mismatch goes to ERR.
  - DONE: behaves like IDLE. 0xA5 starts a new frame.
  - ERR: error=1, cpu_hold stays 1. Bytes are discarded until 0xA5, which restarts at LEN (error cleared).
- Words already written before an error are not rolled back.
- wr_addr must not wrap: N ≤ CMD_MEM_SIZE guarantees a maximum address of CMD_MEM_SIZE-1.
- The running XOR is cleared on header accept.

## Timing
- Reset values: state=IDLE, in_ready=0 while reset is asserted and 1 in the first cycle after. wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, word_count=0.
- in_ready is 1 in every state except WRITE. It is a combinational function of state.
- Latency: wr_en asserts in the cycle after byte2 is accepted. wr_data and wr_addr are stable during that cycle. word_count and wr_addr update at the end of it.
- Minimum of 4 cycles per word. Back-to-back in_valid stalls for one cycle per word.
- done/error/cpu_hold update in the cycle after the deciding byte is accepted.
- in_valid low in any state: the loader waits with no state change and no timeout.
- Reset mid-frame: everything returns to reset values, cpu_hold drops, and partial memory contents are left as-is.

## Structure
- Shared package `cpu_pkg`: CMD_SIZE, CMD_MEM_SIZE, CMD_ADDR_SIZE, opcode constants (NOP..DIV), and FRAME_HDR=8'hA5. The CPU core and the loader both import it.
- Loader FSM state enum also lives in `cpu_pkg`.
- No sub-module needed. Optionally factor `byte_packer` (3 bytes to CMD_SIZE word), but inline is preferred.

## Test plan
- Single word: A5, 01, 00, 8C, 05, 89. Required: one wr_en with addr 0, data 19'h08C05 (LTM m[3]=5). Then done=1, cpu_hold=0, word_count=1.
- Full memory: A5, 20, 32 words of value i, correct XOR. Required: 32 writes at addrs 0..31 with data i, no wrap, done=1, word_count=32.
- Bad checksum: same as the first case but checksum 0x88. Required: the write still happens, then error=1, cpu_hold=1, done=0. A following valid frame clears error and sets done.
- Framing errors: length 0x00, length 0x21, and byte0=0x08 each produce ERR with no further wr_en. Garbage bytes 0x00/0xFF in ERR and IDLE are ignored.
- Backpressure/gaps: random in_valid gaps plus a check that in_ready=0 in WRITE cycles. Required: data is identical to the gap-free run.
- Reset mid-frame after 2 words of N=4: all outputs go to reset values next cycle. A new frame then loads from addr 0.
